// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiplier, restoring divider, shared 64-bit register).
// Latency: 33 cycles from the accepting edge to the done cycle; 1 cycle for special cases when MULDIV_FAST_SPECIAL_EN is defined.
// Backpressure: busy stalls the core during CALC; start is ignored while busy, and is accepted in IDLE or DONE.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;        // product accumulator, or {remainder, dividend/quotient}
  logic [63:0] acc_nxt;
  logic [31:0] opr;        // multiplicand magnitude or divisor magnitude
  logic [2:0]  op;
  logic        neg;        // sign to apply to the selected result
  logic        spec_hit;   // divide special case: override the iteration output
  logic [31:0] spec_val;

  logic        accept;
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] ma, mb;
  logic        div0, ovf;
  logic [31:0] spec_in_val;
  logic        fast_skip;
  logic [32:0] sum, rem_sh, diff;
  logic [63:0] prod;
  logic [31:0] quo, rem, res_final;

  assign accept = start && (state != CALC);

  // Operand decode at accept: signedness, magnitudes and special-case detection
  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    sa       = a_signed && operand_a[31];
    sb       = b_signed && operand_b[31];
    ma       = sa ? (32'd0 - operand_a) : operand_a;
    mb       = sb ? (32'd0 - operand_b) : operand_b;
    div0     = funct3[2] && (operand_b == 32'd0);
    ovf      = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
               (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    spec_in_val = 32'd0;
    if (div0)
      spec_in_val = funct3[1] ? operand_a : 32'hFFFF_FFFF;
    else if (ovf)
      spec_in_val = funct3[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_SPECIAL_EN
    fast_skip = div0 || ovf ||
                ((funct3 == 3'd0) && ((operand_a == 32'd0) || (operand_b == 32'd0)));
`else
    fast_skip = 1'b0;
`endif
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opr} : 33'd0);
    rem_sh  = acc[63:31];
    diff    = rem_sh - {1'b0, opr};
    acc_nxt = {sum, acc[31:1]};
    if (op[2]) begin
      if (!diff[32])
        acc_nxt = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_nxt = {rem_sh[31:0], acc[30:0], 1'b0};
    end
  end

  // Sign correction and half/quotient/remainder selection from the final iteration
  always_comb begin
    prod = neg ? (64'd0 - acc_nxt) : acc_nxt;
    quo  = neg ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    rem  = neg ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
    if (op[2])
      res_final = op[1] ? rem : quo;
    else
      res_final = (op == 3'd0) ? prod[31:0] : prod[63:32];
    if (spec_hit)
      res_final = spec_val;
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opr      <= 32'd0;
      op       <= 3'd0;
      neg      <= 1'b0;
      spec_hit <= 1'b0;
      spec_val <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
    end else if (accept) begin
      op       <= funct3;
      opr      <= funct3[2] ? mb : ma;
      acc      <= {32'd0, funct3[2] ? ma : mb};
      neg      <= (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
      spec_hit <= div0 || ovf;
      spec_val <= spec_in_val;
      cnt      <= 5'd31;
      if (fast_skip) begin
        state  <= DONE;
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= spec_in_val;
      end else begin
        state  <= CALC;
        busy   <= 1'b1;
        done   <= 1'b0;
      end
    end else begin
      case (state)
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_final;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for all eight operations, divide special cases,
// latency, asynchronous reset mid-operation and back-to-back starts.
// Special-case latency expectation follows MULDIV_FAST_SPECIAL_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
    string       name;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, scramble inputs after the accepting edge, wait for done (bounded)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic overlap);
    @(negedge clk);
    funct3 = f3; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = ~f3; operand_a = ~a; operand_b = ~b;
    lat = -1;
    overlap = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          exp_lat;
    logic        ov;
    logic        saw_done;
    int          done_cnt;
    int          done_cyc[2];
    logic [31:0] done_res[2];

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3"};
    vecs[1]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "mulh_7_m3"};
    vecs[2]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, "mulhu_7_m3"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1_max"};
    vecs[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min"};
    vecs[5]  = '{3'd0, 32'd12345,     32'd6789,      32'h04FE_D79D, 1'b0, "mul_12345_6789"};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2"};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2"};
    vecs[8]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7"};
    vecs[9]  = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7"};
    vecs[10] = '{3'd4, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, "div_m100_7"};
    vecs[11] = '{3'd6, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0, "rem_m100_7"};
    vecs[12] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div_5_0"};
    vecs[13] = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1, "rem_5_0"};
    vecs[14] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"};
    vecs[15] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "rem_ovf"};
    vecs[16] = '{3'd0, 32'd0,         32'd123,       32'd0,         1'b1, "mul_0_123"};
    vecs[17] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "divu_5_0"};
    vecs[18] = '{3'd7, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1, "remu_m7_0"};

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors with latency and busy/done exclusivity
    for (int v = 0; v < 19; v++) begin
      run_op(vecs[v].f3, vecs[v].a, vecs[v].b, res, lat, ov);
      check({vecs[v].name, "_result"}, res, vecs[v].exp);
`ifdef MULDIV_FAST_SPECIAL_EN
      exp_lat = vecs[v].special ? 0 : 32;
`else
      exp_lat = 32;
`endif
      check({vecs[v].name, "_latency"}, lat, exp_lat);
      check({vecs[v].name, "_busy_done_overlap"}, {31'd0, ov}, 32'd0);
    end

    // Asynchronous reset mid-CALC aborts without a done pulse
    @(negedge clk);
    funct3 = 3'd5; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("postreset_no_done", {31'd0, saw_done}, 32'd0);
    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFD, res, lat, ov);
    check("postreset_mulhu_result", res, 32'd6);
    check("postreset_mulhu_latency", lat, 32);

    // Back-to-back: start held high, operands change mid-CALC
    @(negedge clk);
    funct3 = 3'd0; operand_a = 32'h0000_0007; operand_b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    #1;
    done_cnt = 0;
    done_cyc[0] = -1; done_cyc[1] = -1;
    done_res[0] = 32'd0; done_res[1] = 32'd0;
    ov = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) begin
        funct3 = 3'd5; operand_a = 32'd100; operand_b = 32'd7;
      end
      if (busy && done) ov = 1'b1;
      if (done) begin
        done_cyc[done_cnt] = i;
        done_res[done_cnt] = result;
        done_cnt++;
        if (done_cnt == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_done_count", done_cnt, 2);
    check("b2b_first_cycle", done_cyc[0], 32);
    check("b2b_first_result", done_res[0], 32'hFFFF_FFEB);
    check("b2b_second_cycle", done_cyc[1], 65);
    check("b2b_second_result", done_res[1], 32'd14);
    check("b2b_busy_done_overlap", {31'd0, ov}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);
    check("b2b_result_held", result, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the single-cycle `alu` in the execute stage. It receives the operand pair the ALU receives, plus `funct3`, under a start/done handshake. It computes all eight M-extension operations over multiple cycles and stalls the core via `busy` until the result is ready. Internally it uses unsigned magnitudes: a radix-2 shift-add multiplier and a restoring divider, sharing one 64-bit working register.

## Interface
Parameters: none; the datapath is fixed at 32 bits.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled on a rising edge while `busy`=0.
- `funct3` input 3: operation select. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operand_a` input 32: rs1 value (multiplicand / dividend); sampled with `start`.
- `operand_b` input 32: rs2 value (multiplier / divisor); sampled with `start`.
- `busy` output 1: high while in CALC.
- `done` output 1: one-cycle pulse; `result` is valid.
- `result` output 32: final value; held until the next accepted `start`.

## Operation
States:
- IDLE: wait for `start`.
- CALC: 32 iterations; a 5-bit counter runs 31 down to 0.
- DONE: sign correction and result latch; `done`=1.

Transitions:
- IDLE -> CALC on `start`.
- CALC -> DONE when the counter reaches 0.
- DONE -> CALC if `start`=1 (back-to-back), else DONE -> IDLE.

Reset:
- State IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- Reset asserted mid-CALC aborts the operation; no `done` pulse follows.

Sign handling at accept:
- Signed operands (DIV, REM, MULH both; MULHSU `operand_a` only) are converted to magnitudes.
- Result sign is recorded: product sign = sa XOR sb; quotient sign = sa XOR sb; remainder sign = sa.

Arithmetic:
- MUL returns the low 32 bits of the product; MULH/MULHSU/MULHU return the high 32 bits.
- Negation of the 64-bit product happens before selecting the half.
- DIV/DIVU return the quotient, REM/REMU the remainder. Division truncates toward zero.

Divide special cases (RISC-V spec):
- Divisor 0: quotient = 0xFFFFFFFF; remainder = `operand_a`.
- DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

Other rules:
- `start` while `busy`=1 is ignored; operands and `funct3` changing during CALC have no effect.
- `result` and `done` depend only on the internal registers, with no combinational path from the inputs.

## Timing
- `start` is sampled at edge E0. `busy` is high from E0 to E32 (32 cycles). `done` and the new `result` are visible from E32 to E33.
- Latency: 33 cycles from the accepting edge to the `done` cycle.
- Throughput with back-to-back starts: one operation per 33 cycles. `start` high during the DONE cycle is accepted at E33.
- `busy` and `done` are never high together.
- `result` changes only on the edge that enters DONE.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined:
  - Divide-by-zero and signed-overflow divisions skip CALC. IDLE/DONE -> DONE directly, so `done` appears at E0–E1 (1-cycle latency) and `busy` stays 0.
  - MUL with either operand 0 also completes in 1 cycle with `result`=0.
- `MULDIV_FAST_SPECIAL_EN` undefined:
  - Every operation takes the full 33 cycles.
  - Special-case values are forced in DONE; the iteration output is discarded.

## Test plan
- Reset during CALC at cycle 10 -> `busy`=0 and `result`=0 immediately (asynchronous); no `done` after release; a new start then works normally.
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) -> `result`=0xFFFFFFEB; MULH same -> 0xFFFFFFFF; MULHU same -> 0x00000006; `done` at E32.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULH 0x80000000 × 0x80000000 -> 0x40000000.
- DIV −7 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / −1 -> 0x80000000; REM -> 0. Check the 1-cycle latency with `MULDIV_FAST_SPECIAL_EN` and 33 cycles without.
- Back-to-back: `start` held high continuously with a mid-CALC operand change -> the second op is accepted at E33, its `done` comes at E65, and both results match the operands sampled at their accept edges.
